// File: rtl/nn_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the XOR network datapath blocks.
package nn_fixed_pkg;

  localparam int FRAC_W = 8;

  localparam logic signed [15:0] ONE_Q88 = 16'sh0100;
  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    OUT_DELTA,
    HID_DELTA,
    GRAD,
    UPDATE,
    DONE
  } bp_state_t;

  // Clamp a 32-bit signed value into the signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sh0000_7FFF) begin
      return SAT_MAX;
    end else if (v < -32'sh0000_8000) begin
      return SAT_MIN;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/backward_propagation_if.sv
// Snapshot-in / updated-parameters-out bundle of the backward-pass engine.
interface backward_propagation_if #(
  parameter int DATA_W = 16
);
  logic                     enable_bp;
  logic signed [DATA_W-1:0] x1, x2, target;
  logic signed [DATA_W-1:0] h1, h2, y;
  logic signed [DATA_W-1:0] w11, w12, w21, w22, w31, w32;
  logic signed [DATA_W-1:0] b1, b2, b3;
  logic signed [DATA_W-1:0] lr;
  logic signed [DATA_W-1:0] w11_upd, w12_upd, w21_upd, w22_upd, w31_upd, w32_upd;
  logic signed [DATA_W-1:0] b1_upd, b2_upd, b3_upd;
  logic                     bp_valid;

  modport master (
    output enable_bp, x1, x2, target, h1, h2, y,
           w11, w12, w21, w22, w31, w32, b1, b2, b3, lr,
    input  w11_upd, w12_upd, w21_upd, w22_upd, w31_upd, w32_upd,
           b1_upd, b2_upd, b3_upd, bp_valid
  );

  modport slave (
    input  enable_bp, x1, x2, target, h1, h2, y,
           w11, w12, w21, w22, w31, w32, b1, b2, b3, lr,
    output w11_upd, w12_upd, w21_upd, w22_upd, w31_upd, w32_upd,
           b1_upd, b2_upd, b3_upd, bp_valid
  );
endinterface

// File: rtl/fxp_sgd_update.sv
// One SGD step on a single parameter: p_upd = sat(p - sat((lr * g) >>> FRAC_W)).
module fxp_sgd_update #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic signed [DATA_W-1:0] p,
  input  logic signed [DATA_W-1:0] g,
  input  logic signed [DATA_W-1:0] lr,
  output logic signed [DATA_W-1:0] p_upd
);
  import nn_fixed_pkg::*;

  logic signed [31:0]     prod;
  logic signed [DATA_W-1:0] step;
  logic signed [DATA_W:0]   diff;

  // lr is zero-extended so the rate is always a non-negative scale factor.
  always_comb begin
    prod  = 32'($signed({1'b0, lr})) * 32'(g);
    step  = sat16(prod >>> FRAC_W);
    diff  = {p[DATA_W-1], p} - {step[DATA_W-1], step};
    p_upd = sat16(32'(diff));
  end

endmodule

// File: rtl/backward_propagation.sv
// Backward pass and SGD update for the 2-2-1 XOR network (ReLU hidden, sigmoid out).
module backward_propagation #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  backward_propagation_if.slave  bus
);
  import nn_fixed_pkg::*;

  // Parameter/gradient slot order: w11 w12 w21 w22 w31 w32 b1 b2 b3
  localparam int NP  = 9;
  localparam int W31 = 4;
  localparam int W32 = 5;

  bp_state_t state;

  logic signed [DATA_W-1:0] x1_q, x2_q, tgt_q, h1_q, h2_q, y_q, lr_q;
  logic signed [DATA_W-1:0] p_q   [NP];
  logic signed [DATA_W-1:0] g_q   [NP];
  logic signed [DATA_W-1:0] upd_q [NP];
  logic signed [DATA_W-1:0] d1_q, d2_q, d3_q;
  logic                     bp_valid_q;

  logic signed [DATA_W:0]   out_err;
  logic signed [31:0]       prod_d1, prod_d2;
  logic signed [31:0]       gp [6];
  logic signed [DATA_W-1:0] d1_next, d2_next, d3_next;
  logic signed [DATA_W-1:0] g_next   [NP];
  logic signed [DATA_W-1:0] upd_next [NP];

  // Delta and gradient datapath, evaluated from the registers of the previous stage.
  always_comb begin
    out_err = {y_q[DATA_W-1], y_q} - {tgt_q[DATA_W-1], tgt_q};
    d3_next = sat16(32'(out_err));
    prod_d1 = 32'(p_q[W31]) * 32'(d3_q);
    prod_d2 = 32'(p_q[W32]) * 32'(d3_q);
    d1_next = (h1_q > 0) ? sat16(prod_d1 >>> FRAC_W) : '0;
    d2_next = (h2_q > 0) ? sat16(prod_d2 >>> FRAC_W) : '0;
    gp[0] = (32'(d1_q) * 32'(x1_q)) >>> FRAC_W;
    gp[1] = (32'(d1_q) * 32'(x2_q)) >>> FRAC_W;
    gp[2] = (32'(d2_q) * 32'(x1_q)) >>> FRAC_W;
    gp[3] = (32'(d2_q) * 32'(x2_q)) >>> FRAC_W;
    gp[4] = (32'(d3_q) * 32'(h1_q)) >>> FRAC_W;
    gp[5] = (32'(d3_q) * 32'(h2_q)) >>> FRAC_W;
    for (int unsigned i = 0; i < 6; i++) begin
      g_next[i] = gp[i][DATA_W-1:0];
    end
    g_next[6] = d1_q;
    g_next[7] = d2_q;
    g_next[8] = d3_q;
  end

  for (genvar i = 0; i < NP; i++) begin : g_upd
    fxp_sgd_update #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_upd (
      .p     (p_q[i]),
      .g     (g_q[i]),
      .lr    (lr_q),
      .p_upd (upd_next[i])
    );
  end

  // Sequencer: latch snapshot, then one pipeline step per state, pulse on DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bp_valid_q <= 1'b0;
      x1_q  <= '0; x2_q <= '0; tgt_q <= '0;
      h1_q  <= '0; h2_q <= '0; y_q   <= '0; lr_q <= '0;
      d1_q  <= '0; d2_q <= '0; d3_q  <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        p_q[i]   <= '0;
        g_q[i]   <= '0;
        upd_q[i] <= '0;
      end
    end else begin
      bp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable_bp) begin
            x1_q  <= bus.x1;  x2_q <= bus.x2;  tgt_q <= bus.target;
            h1_q  <= bus.h1;  h2_q <= bus.h2;  y_q   <= bus.y;
            lr_q  <= bus.lr;
            p_q[0] <= bus.w11; p_q[1] <= bus.w12; p_q[2] <= bus.w21;
            p_q[3] <= bus.w22; p_q[4] <= bus.w31; p_q[5] <= bus.w32;
            p_q[6] <= bus.b1;  p_q[7] <= bus.b2;  p_q[8] <= bus.b3;
            state <= OUT_DELTA;
          end
        end
        OUT_DELTA: begin
          d3_q  <= d3_next;
          state <= HID_DELTA;
        end
        HID_DELTA: begin
          d1_q  <= d1_next;
          d2_q  <= d2_next;
          state <= GRAD;
        end
        GRAD: begin
          for (int unsigned i = 0; i < NP; i++) g_q[i] <= g_next[i];
          state <= UPDATE;
        end
        UPDATE: begin
          for (int unsigned i = 0; i < NP; i++) upd_q[i] <= upd_next[i];
          state <= DONE;
        end
        DONE: begin
          bp_valid_q <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.w11_upd  = upd_q[0];
  assign bus.w12_upd  = upd_q[1];
  assign bus.w21_upd  = upd_q[2];
  assign bus.w22_upd  = upd_q[3];
  assign bus.w31_upd  = upd_q[4];
  assign bus.w32_upd  = upd_q[5];
  assign bus.b1_upd   = upd_q[6];
  assign bus.b2_upd   = upd_q[7];
  assign bus.b3_upd   = upd_q[8];
  assign bus.bp_valid = bp_valid_q;

endmodule

// File: tb/tb_backward_propagation.sv
// Self-checking bench for backward_propagation against an integer reference model.
module tb_backward_propagation;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  backward_propagation_if #(.DATA_W(16)) bus ();

  backward_propagation #(.DATA_W(16), .FRAC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Sample under test; parameter order w11 w12 w21 w22 w31 w32 b1 b2 b3
  int in_x1, in_x2, in_t, in_h1, in_h2, in_y, in_lr;
  int in_p  [9];
  int exp_u [9];
  logic signed [15:0] obs [9];
  string pname [9] = '{"w11", "w12", "w21", "w22", "w31", "w32", "b1", "b2", "b3"};

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int rand16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // Reference: deltas, gradients and SGD step straight from the network equations.
  function automatic void compute_model();
    int d1, d2, d3;
    int g [9];
    d3 = clamp(in_y - in_t);
    d1 = (in_h1 > 0) ? clamp((in_p[4] * d3) >>> 8) : 0;
    d2 = (in_h2 > 0) ? clamp((in_p[5] * d3) >>> 8) : 0;
    g[0] = wrap16((d1 * in_x1) >>> 8);
    g[1] = wrap16((d1 * in_x2) >>> 8);
    g[2] = wrap16((d2 * in_x1) >>> 8);
    g[3] = wrap16((d2 * in_x2) >>> 8);
    g[4] = wrap16((d3 * in_h1) >>> 8);
    g[5] = wrap16((d3 * in_h2) >>> 8);
    g[6] = d1;
    g[7] = d2;
    g[8] = d3;
    for (int i = 0; i < 9; i++) exp_u[i] = clamp(in_p[i] - clamp((in_lr * g[i]) >>> 8));
  endfunction

  task automatic apply_inputs();
    bus.x1 = 16'(in_x1); bus.x2 = 16'(in_x2); bus.target = 16'(in_t);
    bus.h1 = 16'(in_h1); bus.h2 = 16'(in_h2); bus.y = 16'(in_y);
    bus.lr = 16'(in_lr);
    bus.w11 = 16'(in_p[0]); bus.w12 = 16'(in_p[1]); bus.w21 = 16'(in_p[2]);
    bus.w22 = 16'(in_p[3]); bus.w31 = 16'(in_p[4]); bus.w32 = 16'(in_p[5]);
    bus.b1  = 16'(in_p[6]); bus.b2  = 16'(in_p[7]); bus.b3  = 16'(in_p[8]);
  endtask

  task automatic capture();
    obs[0] = bus.w11_upd; obs[1] = bus.w12_upd; obs[2] = bus.w21_upd;
    obs[3] = bus.w22_upd; obs[4] = bus.w31_upd; obs[5] = bus.w32_upd;
    obs[6] = bus.b1_upd;  obs[7] = bus.b2_upd;  obs[8] = bus.b3_upd;
  endtask

  task automatic rand_sample();
    in_x1 = int'($urandom_range(0, 512)) - 256;
    in_x2 = int'($urandom_range(0, 512)) - 256;
    in_h1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 256));
    in_h2 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 256));
    in_y  = int'($urandom_range(0, 256));
    in_t  = ($urandom_range(0, 1) == 0) ? 0 : 256;
    in_lr = int'($urandom_range(0, 512));
    for (int i = 0; i < 9; i++) in_p[i] = rand16();
  endtask

  // Pulse enable_bp for one edge, wait (bounded) for bp_valid, capture outputs.
  task automatic do_pass(output int lat, output logic after_low);
    apply_inputs();
    bus.enable_bp = 1'b1;
    @(posedge clk); #1;
    bus.enable_bp = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (bus.bp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    capture();
    @(posedge clk); #1;
    after_low = (bus.bp_valid === 1'b0);
  endtask

  task automatic test_reset();
    bus.enable_bp = 1'b0;
    for (int i = 0; i < 9; i++) in_p[i] = 0;
    in_x1 = 0; in_x2 = 0; in_t = 0; in_h1 = 0; in_h2 = 0; in_y = 0; in_lr = 0;
    apply_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    capture();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'sh0000) begin
        errors++;
        $display("FAIL reset_%s got %h want 0000", pname[i], obs[i]);
      end
    end
    checks++;
    if (bus.bp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_bp_valid got %b want 0", bus.bp_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    logic low;
    int want [9] = '{16'h00C0, 16'h0090, 16'h0010, 16'h0010, 16'h0180, 16'h0010, 16'h0080, 16'h0010, 16'h0080};
    in_x1 = 256; in_x2 = 256; in_t = 256; in_y = 128; in_h1 = 256; in_h2 = 0; in_lr = 256;
    in_p = '{64, 16, 16, 16, 256, 256, 0, 16, 0};
    want[5] = 256;
    do_pass(lat, low);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++;
    if (!low) begin errors++; $display("FAIL basic_pulse_width got high want low"); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'(want[i])) begin
        errors++;
        $display("FAIL basic_%s got %h want %h", pname[i], obs[i], 16'(want[i]));
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic low;
    in_x1 = 0; in_x2 = 0; in_t = 256; in_y = 0; in_h1 = 1024; in_h2 = 0; in_lr = 256;
    for (int i = 0; i < 9; i++) in_p[i] = 0;
    in_p[4] = 32'h7F00;
    compute_model();
    do_pass(lat, low);
    checks++;
    if (obs[4] !== 16'sh7FFF) begin
      errors++;
      $display("FAIL sat_w31 got %h want 7fff", obs[4]);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'(exp_u[i])) begin
        errors++;
        $display("FAIL sat_%s got %h want %h", pname[i], obs[i], 16'(exp_u[i]));
      end
    end
  endtask

  task automatic test_relu_gate();
    int lat;
    logic low;
    for (int n = 0; n < 3; n++) begin
      rand_sample();
      in_h1 = 0; in_h2 = 0;
      in_t = 256;
      in_y = int'($urandom_range(0, 255));
      in_lr = int'($urandom_range(64, 512));
      compute_model();
      do_pass(lat, low);
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs[i] !== 16'(in_p[i])) begin
          errors++;
          $display("FAIL relu_%s got %h want %h", pname[i], obs[i], 16'(in_p[i]));
        end
      end
      checks++;
      if (obs[8] !== 16'(exp_u[8])) begin
        errors++;
        $display("FAIL relu_b3 got %h want %h", obs[8], 16'(exp_u[8]));
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic low;
    for (int n = 0; n < 25; n++) begin
      rand_sample();
      compute_model();
      do_pass(lat, low);
      checks++;
      if (lat != 5) begin errors++; $display("FAIL rand_latency got %0d want 5", lat); end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (obs[i] !== 16'(exp_u[i])) begin
          errors++;
          $display("FAIL rand_%s got %h want %h", pname[i], obs[i], 16'(exp_u[i]));
        end
      end
    end
  endtask

  task automatic test_zero_lr();
    int lat;
    logic low;
    rand_sample();
    in_lr = 0;
    do_pass(lat, low);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL zlr_latency got %0d want 5", lat); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'(in_p[i])) begin
        errors++;
        $display("FAIL zlr_%s got %h want %h", pname[i], obs[i], 16'(in_p[i]));
      end
    end
  endtask

  task automatic test_ignore_second();
    int pulses = 0;
    int first = -1;
    int exp_a [9];
    rand_sample();
    compute_model();
    exp_a = exp_u;
    apply_inputs();
    bus.enable_bp = 1'b1;
    @(posedge clk); #1;
    bus.enable_bp = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) begin
        rand_sample();
        apply_inputs();
        bus.enable_bp = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 2) bus.enable_bp = 1'b0;
      if (bus.bp_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          capture();
        end
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    checks++;
    if (first != 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", first); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'(exp_a[i])) begin
        errors++;
        $display("FAIL ignore_%s got %h want %h", pname[i], obs[i], 16'(exp_a[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    rand_sample();
    apply_inputs();
    bus.enable_bp = 1'b1;
    @(posedge clk); #1;
    bus.enable_bp = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    capture();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'sh0000) begin
        errors++;
        $display("FAIL midrst_%s got %h want 0000", pname[i], obs[i]);
      end
    end
    checks++;
    if (bus.bp_valid !== 1'b0) begin errors++; $display("FAIL midrst_bp_valid got %b want 0", bus.bp_valid); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.bp_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int p1 = -1;
    int p2 = -1;
    rand_sample();
    compute_model();
    apply_inputs();
    bus.enable_bp = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 7) bus.enable_bp = 1'b0;
      if (bus.bp_valid === 1'b1) begin
        pulses++;
        if (p1 < 0) p1 = k;
        else if (p2 < 0) begin
          p2 = k;
          capture();
        end
      end
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++;
    if (p1 != 5) begin errors++; $display("FAIL b2b_first got %0d want 5", p1); end
    checks++;
    if (p2 != 11) begin errors++; $display("FAIL b2b_second got %0d want 11", p2); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs[i] !== 16'(exp_u[i])) begin
        errors++;
        $display("FAIL b2b_%s got %h want %h", pname[i], obs[i], 16'(exp_u[i]));
      end
    end
  endtask

  initial begin
    bus.enable_bp = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_relu_gate();
    test_random();
    test_zero_lr();
    test_ignore_second();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backward_propagation.md
# backward_propagation

Backward-pass and weight-update engine for the 2-2-1 XOR network: ReLU hidden layer, sigmoid output, Q8.8 fixed point. It consumes one forward-pass snapshot: inputs, target, h1/h2/y and the weights and biases that produced them. It computes output and hidden deltas and the nine gradients, then emits one SGD-updated parameter set with a single-cycle `bp_valid` pulse. It sits between `forward_propagation` (`*_out`, `fp_valid`) and the parameter registers that feed the next forward pass.

## Interface
Parameters:
- `DATA_W`, default 16: signed word width.
- `FRAC_W`, default 8: fractional bits (Q8.8).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable_bp` input 1: start request; sampled only in IDLE.
- `x1`, `x2` input DATA_W each: network inputs of the sample.
- `target` input DATA_W: expected output (0x0000 or 0x0100).
- `h1`, `h2`, `y` input DATA_W each: forward activations.
- `w11`, `w12`, `w21`, `w22`, `w31`, `w32` input DATA_W each: weights used by the forward pass.
- `b1`, `b2`, `b3` input DATA_W each: biases used by the forward pass.
- `lr` input DATA_W: learning rate, Q8.8, treated as non-negative.
- `w11_upd` … `w32_upd`, `b1_upd`, `b2_upd`, `b3_upd` output reg DATA_W each: updated parameters.
- `bp_valid` output reg 1: one-cycle pulse when all `*_upd` are valid.

## Operation
- States: IDLE, OUT_DELTA, HID_DELTA, GRAD, UPDATE, DONE. Every state except IDLE advances unconditionally: DONE→IDLE.
- IDLE:
  - If `enable_bp`=1, latch all inputs into internal registers and go to OUT_DELTA.
  - Inputs may change afterwards without effect.
- OUT_DELTA: `d3 = sat(y − target)`. This is the sigmoid + cross-entropy form; no y(1−y) term.
- HID_DELTA:
  - `d1 = (h1 > 0) ? sat((w31·d3) >>> 8) : 0`.
  - `d2` is computed the same way with `h2` and `w32`.
  - Uses the pre-update `w31`/`w32`.
- GRAD:
  - `g31 = (d3·h1)>>>8`, `g32 = (d3·h2)>>>8`, `gb3 = d3`.
  - `g11 = (d1·x1)>>>8`, `g12 = (d1·x2)>>>8`, `gb1 = d1`.
  - `g21`, `g22`, `gb2` are computed the same way from `d2`.
- UPDATE: for each parameter p, `p_upd = sat(p − sat((lr·g_p) >>> 8))`.
- DONE: `bp_valid` ← 1, state ← IDLE.
- Arithmetic rules:
  - Products are full 32-bit signed.
  - `>>>` is arithmetic, truncating toward −∞.
  - Sums and differences use 17 bits.
  - `sat` clamps to [0x8000, 0x7FFF].
  - Stored gradients and deltas are DATA_W.
- `enable_bp` outside IDLE is ignored; requests are not queued.
- `*_upd` hold their value until the next UPDATE.

## Timing
- Reset: state=IDLE; all `*_upd`=0; `bp_valid`=0; internal delta/gradient registers=0.
- `enable_bp` sampled high at edge N. Then `bp_valid`=1 and the final `*_upd` are visible after edge N+5.
- `bp_valid` is high for exactly one cycle and is low after edge N+6.
- Back-to-back: `enable_bp` held high restarts at edge N+6, giving a 6-cycle throughput.
- `rst` asserted mid-operation: at that edge state→IDLE and all outputs→0. No `bp_valid` is produced for the aborted pass.
- `rst` and `enable_bp` both high at the same edge: reset wins.

## Structure
- Shared package `nn_fixed_pkg`: `FRAC_W`, `ONE_Q88 = 16'h0100`, `SAT_MAX`/`SAT_MIN`, function `sat16` (32→16 signed clamp), and the `bp_state_t` enum. `forward_propagation` reuses the package.
- One sub-module, `fxp_sgd_update`: combinational `p_upd = sat(p − sat(lr·g >>> 8))`. It is instantiated 9× in UPDATE.

## Test plan
- Basic update:
  - Stimulus: x1=x2=0x0100, target=0x0100, y=0x0080, h1=0x0100, h2=0, w11=0x0040, w31=w32=0x0100, b1=b3=0, other parameters=0x0010, lr=0x0100.
  - Expect w31_upd=0x0180, b3_upd=0x0080, w11_upd=0x00C0, w12_upd=0x0090, b1_upd=0x0080.
  - Expect w32, w21, w22, b2 unchanged at their input values.
- Saturation:
  - Stimulus: w31=0x7F00, y=0, target=0x0100, h1=0x0400, lr=0x0100.
  - Expect w31_upd=0x7FFF, not wrapped to 0x8300.
- ReLU gate: h1=h2=0, any d3 → all hidden-layer `*_upd` equal their inputs; only b3 changes.
- Latency and pulse:
  - `enable_bp` one cycle at edge N → `bp_valid` high only in the cycle after edge N+5.
  - A second `enable_bp` at N+2 is ignored: no extra pulse, and outputs reflect the first sample.
- Reset mid-pass: `rst` at edge N+3 → all outputs 0 at N+3, no `bp_valid` within 10 cycles.
- Zero learning rate: lr=0 → every `*_upd` equals its input parameter, and `bp_valid` still pulses at N+5.
